// File: rtl/riscv_core_hazard_fwd_unit_pkg.sv
// Shared types for the RV32IMC pipeline hazard/forwarding control.
// Forwarding-select encoding and hazard FSM states live here.
package riscv_core_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/riscv_core_hazard_fwd_unit_if.sv
// Pipeline-side bundle between the ID/EX/MEM/WB registers and the hazard unit.
interface riscv_core_hazard_fwd_unit_if #(
  parameter int REG_AW = riscv_core_pkg::REG_AW,
  parameter int CNT_W  = 32
);
  import riscv_core_pkg::*;

  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_use_rs1;
  logic              i_id_use_rs2;
  logic [REG_AW-1:0] i_ex_rs1;
  logic [REG_AW-1:0] i_ex_rs2;
  logic [REG_AW-1:0] i_ex_rd;
  logic              i_ex_reg_we;
  logic              i_ex_is_load;
  logic              i_ex_md_start;
  logic              i_md_done;
  logic              i_ex_redirect;
  logic [REG_AW-1:0] i_mem_rd;
  logic              i_mem_reg_we;
  logic [REG_AW-1:0] i_wb_rd;
  logic              i_wb_reg_we;
  fwd_sel_t          o_fwd_a_sel;
  fwd_sel_t          o_fwd_b_sel;
  logic              o_stall_if;
  logic              o_stall_id;
  logic              o_stall_ex;
  logic              o_flush_id;
  logic              o_flush_ex;
  logic              o_md_busy;
  logic [CNT_W-1:0]  o_stall_cycles;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
    output i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_reg_we, i_ex_is_load,
    output i_ex_md_start, i_md_done, i_ex_redirect,
    output i_mem_rd, i_mem_reg_we, i_wb_rd, i_wb_reg_we,
    input  o_fwd_a_sel, o_fwd_b_sel, o_stall_if, o_stall_id, o_stall_ex,
    input  o_flush_id, o_flush_ex, o_md_busy, o_stall_cycles
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
    input  i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_reg_we, i_ex_is_load,
    input  i_ex_md_start, i_md_done, i_ex_redirect,
    input  i_mem_rd, i_mem_reg_we, i_wb_rd, i_wb_reg_we,
    output o_fwd_a_sel, o_fwd_b_sel, o_stall_if, o_stall_id, o_stall_ex,
    output o_flush_id, o_flush_ex, o_md_busy, o_stall_cycles
  );

endinterface

// File: rtl/riscv_core_hazard_fwd_unit_fwd_sel.sv
// Operand forwarding comparator: picks MEM over WB, never forwards x0.
module riscv_core_fwd_sel
  import riscv_core_pkg::*;
#(
  parameter int REG_AW = riscv_core_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_reg_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_reg_we,
  output fwd_sel_t          o_sel
);

  logic mem_hit_s;
  logic wb_hit_s;

  assign mem_hit_s = i_mem_reg_we && (i_mem_rd != {REG_AW{1'b0}}) && (i_mem_rd == i_ex_rs);
  assign wb_hit_s  = i_wb_reg_we  && (i_wb_rd  != {REG_AW{1'b0}}) && (i_wb_rd  == i_ex_rs);

  // Priority select; the youngest producer (MEM) wins over WB.
  always_comb begin
    o_sel = FWD_RF;
    if (mem_hit_s) begin
      o_sel = FWD_MEM;
    end else if (wb_hit_s) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/riscv_core_hazard_fwd_unit.sv
// Hazard/forwarding control for the 5-stage core: operand forwarding selects,
// load-use and redirect bubbles, div/rem stall FSM and a stall-cycle counter.
module riscv_core_hazard_fwd_unit
  import riscv_core_pkg::*;
#(
  parameter int REG_AW = riscv_core_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input logic                         i_clk,
  input logic                         i_rst,
  riscv_core_hazard_fwd_unit_if.slave bus
);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_s;
  logic             stall_if_s, stall_id_s, stall_ex_s;
  logic             flush_id_s, flush_ex_s, md_busy_s;

  riscv_core_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_ex_rs      (bus.i_ex_rs1),
    .i_mem_rd     (bus.i_mem_rd),
    .i_mem_reg_we (bus.i_mem_reg_we),
    .i_wb_rd      (bus.i_wb_rd),
    .i_wb_reg_we  (bus.i_wb_reg_we),
    .o_sel        (bus.o_fwd_a_sel)
  );

  riscv_core_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_ex_rs      (bus.i_ex_rs2),
    .i_mem_rd     (bus.i_mem_rd),
    .i_mem_reg_we (bus.i_mem_reg_we),
    .i_wb_rd      (bus.i_wb_rd),
    .i_wb_reg_we  (bus.i_wb_reg_we),
    .o_sel        (bus.o_fwd_b_sel)
  );

  assign lu_s = bus.i_ex_is_load && bus.i_ex_reg_we && (bus.i_ex_rd != {REG_AW{1'b0}}) &&
                ((bus.i_id_use_rs1 && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                 (bus.i_id_use_rs2 && (bus.i_id_rs2 == bus.i_ex_rd)));

  // Next-state and stall/flush decode; MD_WAIT masks load-use and redirect.
  always_comb begin
    state_d    = state_q;
    stall_if_s = 1'b0;
    stall_id_s = 1'b0;
    stall_ex_s = 1'b0;
    flush_id_s = 1'b0;
    flush_ex_s = 1'b0;
    md_busy_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_ex_md_start && !bus.i_md_done) begin
          state_d    = MD_WAIT;
          stall_if_s = 1'b1;
          stall_id_s = 1'b1;
          stall_ex_s = 1'b1;
        end else if (bus.i_ex_redirect) begin
          flush_id_s = 1'b1;
          flush_ex_s = 1'b1;
        end else if (lu_s) begin
          stall_if_s = 1'b1;
          stall_id_s = 1'b1;
          flush_ex_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MD_WAIT: begin
        md_busy_s = 1'b1;
        // Release the stalls on the done cycle so EX/MEM captures the result.
        if (bus.i_md_done) begin
          state_d = IDLE;
        end else begin
          stall_if_s = 1'b1;
          stall_id_s = 1'b1;
          stall_ex_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_if_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_stall_if     = stall_if_s;
  assign bus.o_stall_id     = stall_id_s;
  assign bus.o_stall_ex     = stall_ex_s;
  assign bus.o_flush_id     = flush_id_s;
  assign bus.o_flush_ex     = flush_ex_s;
  assign bus.o_md_busy      = md_busy_s;
  assign bus.o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_riscv_core_hazard_fwd_unit.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge
// monitor pops and compares. A second instance with a 4-bit counter checks saturation.
module tb_riscv_core_hazard_fwd_unit;
  import riscv_core_pkg::*;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_core_hazard_fwd_unit_if #(.REG_AW(AW), .CNT_W(32)) bus ();
  riscv_core_hazard_fwd_unit_if #(.REG_AW(AW), .CNT_W(4))  sbus ();

  riscv_core_hazard_fwd_unit #(.REG_AW(AW), .CNT_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  riscv_core_hazard_fwd_unit #(.REG_AW(AW), .CNT_W(4)) dut_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (sbus)
  );

  assign sbus.i_id_rs1      = bus.i_id_rs1;
  assign sbus.i_id_rs2      = bus.i_id_rs2;
  assign sbus.i_id_use_rs1  = bus.i_id_use_rs1;
  assign sbus.i_id_use_rs2  = bus.i_id_use_rs2;
  assign sbus.i_ex_rs1      = bus.i_ex_rs1;
  assign sbus.i_ex_rs2      = bus.i_ex_rs2;
  assign sbus.i_ex_rd       = bus.i_ex_rd;
  assign sbus.i_ex_reg_we   = bus.i_ex_reg_we;
  assign sbus.i_ex_is_load  = bus.i_ex_is_load;
  assign sbus.i_ex_md_start = bus.i_ex_md_start;
  assign sbus.i_md_done     = bus.i_md_done;
  assign sbus.i_ex_redirect = bus.i_ex_redirect;
  assign sbus.i_mem_rd      = bus.i_mem_rd;
  assign sbus.i_mem_reg_we  = bus.i_mem_reg_we;
  assign sbus.i_wb_rd       = bus.i_wb_rd;
  assign sbus.i_wb_reg_we   = bus.i_wb_reg_we;

  typedef struct packed {
    logic [AW-1:0] id_rs1, id_rs2;
    logic          use1, use2;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          ex_we, ex_load, start, done, redir;
    logic [AW-1:0] mem_rd;
    logic          mem_we;
    logic [AW-1:0] wb_rd;
    logic          wb_we;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        sif, sid, sex, fid, fex, busy;
    logic [31:0] cnt;
    logic [3:0]  scnt;
  } exp_t;

  stim_t       s;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_md;       // a divide is outstanding
  longint      m_stalls;   // true number of stalled cycles since reset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs, input logic [AW-1:0] mrd,
                                         input logic mwe, input logic [AW-1:0] wrd, input logic wwe);
    if (mwe && mrd != 5'd0 && mrd == rs) return 2'b10;
    if (wwe && wrd != 5'd0 && wrd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive();
    bus.i_id_rs1      = s.id_rs1;
    bus.i_id_rs2      = s.id_rs2;
    bus.i_id_use_rs1  = s.use1;
    bus.i_id_use_rs2  = s.use2;
    bus.i_ex_rs1      = s.ex_rs1;
    bus.i_ex_rs2      = s.ex_rs2;
    bus.i_ex_rd       = s.ex_rd;
    bus.i_ex_reg_we   = s.ex_we;
    bus.i_ex_is_load  = s.ex_load;
    bus.i_ex_md_start = s.start;
    bus.i_md_done     = s.done;
    bus.i_ex_redirect = s.redir;
    bus.i_mem_rd      = s.mem_rd;
    bus.i_mem_reg_we  = s.mem_we;
    bus.i_wb_rd       = s.wb_rd;
    bus.i_wb_reg_we   = s.wb_we;
  endtask

  // One cycle: apply s, predict this cycle's outputs, advance the model past the edge.
  task automatic step();
    exp_t e;
    logic lu;
    @(posedge clk);
    #1;
    drive();
    e = '0;
    e.fa = fwd_ref(s.ex_rs1, s.mem_rd, s.mem_we, s.wb_rd, s.wb_we);
    e.fb = fwd_ref(s.ex_rs2, s.mem_rd, s.mem_we, s.wb_rd, s.wb_we);
    lu = s.ex_load && s.ex_we && (s.ex_rd != 5'd0) &&
         ((s.use1 && s.id_rs1 == s.ex_rd) || (s.use2 && s.id_rs2 == s.ex_rd));
    if (m_md) begin
      e.busy = 1'b1;
      {e.sif, e.sid, e.sex} = s.done ? 3'b000 : 3'b111;
      m_md = !s.done;
    end else if (s.start && !s.done) begin
      {e.sif, e.sid, e.sex} = 3'b111;
      m_md = 1'b1;
    end else if (s.redir) begin
      {e.fid, e.fex} = 2'b11;
    end else if (lu) begin
      {e.sif, e.sid, e.fex} = 3'b111;
    end
    e.cnt  = 32'(m_stalls);
    e.scnt = (m_stalls > 15) ? 4'd15 : 4'(m_stalls);
    if (e.sif) m_stalls++;
    q.push_back(e);
  endtask

  // Monitor: every presented cycle is compared against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwd_a",     32'(bus.o_fwd_a_sel),  32'(e.fa));
      chk("fwd_b",     32'(bus.o_fwd_b_sel),  32'(e.fb));
      chk("stall_if",  32'(bus.o_stall_if),   32'(e.sif));
      chk("stall_id",  32'(bus.o_stall_id),   32'(e.sid));
      chk("stall_ex",  32'(bus.o_stall_ex),   32'(e.sex));
      chk("flush_id",  32'(bus.o_flush_id),   32'(e.fid));
      chk("flush_ex",  32'(bus.o_flush_ex),   32'(e.fex));
      chk("md_busy",   32'(bus.o_md_busy),    32'(e.busy));
      chk("stall_cnt", bus.o_stall_cycles,    e.cnt);
      chk("sat_cnt",   32'(sbus.o_stall_cycles), 32'(e.scnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s = '0;
    drive();
    m_md = 1'b0;
    m_stalls = 0;
    #3;
    chk("rst_stall_if", 32'(bus.o_stall_if), 32'd0);
    chk("rst_flush_ex", 32'(bus.o_flush_ex), 32'd0);
    chk("rst_busy",     32'(bus.o_md_busy), 32'd0);
    chk("rst_cnt",      bus.o_stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forwarding priority and x0 suppression
    s = '0;
    s.mem_rd = 5'd5; s.mem_we = 1'b1; s.wb_rd = 5'd5; s.wb_we = 1'b1;
    s.ex_rs1 = 5'd5; s.ex_rs2 = 5'd5;
    step();
    s.mem_we = 1'b0;
    step();
    s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.mem_we = 1'b1; s.ex_rs1 = 5'd0; s.ex_rs2 = 5'd0;
    step();

    // Load-use bubble, then the same with a redirect overriding it
    s = '0;
    s.ex_load = 1'b1; s.ex_we = 1'b1; s.ex_rd = 5'd7; s.id_rs2 = 5'd7; s.use2 = 1'b1;
    step();
    s = '0;
    step();
    s.ex_load = 1'b1; s.ex_we = 1'b1; s.ex_rd = 5'd7; s.id_rs2 = 5'd7; s.use2 = 1'b1;
    s.redir = 1'b1;
    step();
    s = '0;
    step();

    // 33-cycle divide
    s.start = 1'b1;
    step();
    s.start = 1'b0;
    repeat (32) step();
    s.done = 1'b1;
    step();
    s = '0;
    step();

    // Early-out divide
    s.start = 1'b1; s.done = 1'b1;
    step();
    s = '0;
    step();

    // Asynchronous reset in the middle of a divide
    s.start = 1'b1;
    step();
    s = '0;
    repeat (5) step();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy",  32'(bus.o_md_busy), 32'd0);
    chk("rst_mid_stall", 32'(bus.o_stall_if), 32'd0);
    chk("rst_mid_cnt",   bus.o_stall_cycles, 32'd0);
    chk("rst_mid_scnt",  32'(sbus.o_stall_cycles), 32'd0);
    m_md = 1'b0;
    m_stalls = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic with small register indices to make hits common
    for (int i = 0; i < 600; i++) begin
      s = '0;
      s.id_rs1  = 5'($urandom_range(0, 3));
      s.id_rs2  = 5'($urandom_range(0, 3));
      s.use1    = 1'($urandom_range(0, 1));
      s.use2    = 1'($urandom_range(0, 1));
      s.ex_rs1  = 5'($urandom_range(0, 3));
      s.ex_rs2  = 5'($urandom_range(0, 3));
      s.ex_rd   = 5'($urandom_range(0, 3));
      s.ex_we   = 1'($urandom_range(0, 1));
      s.ex_load = ($urandom_range(0, 2) == 0);
      s.redir   = ($urandom_range(0, 5) == 0);
      s.mem_rd  = 5'($urandom_range(0, 3));
      s.mem_we  = 1'($urandom_range(0, 1));
      s.wb_rd   = 5'($urandom_range(0, 3));
      s.wb_we   = 1'($urandom_range(0, 1));
      if (m_md) begin
        s.done = ($urandom_range(0, 5) == 0);
      end else if (!s.ex_load && !s.redir && $urandom_range(0, 7) == 0) begin
        s.start = 1'b1;
        s.done  = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    s = '0;
    step();
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
